// File: rtl/if_fetch_q_pkg.sv
// if_fetch_q_pkg: shared fetch constants (InstAddrBus, RstEnable, InstNop) and FSM state encodings
package if_fetch_q_pkg;
  localparam int InstAddrBus = 32;
  localparam logic RstEnable = 1'b1;
  localparam logic [31:0] InstNop = 32'h0000_0013;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH} state_e;
endpackage

// File: rtl/if_fetch_q_sync_fifo.sv
// sync_fifo: W-bit x DEPTH FIFO (clk_i, rst_i async, clr_i, push_i/data_i, pop_i/data_o, count_o, full_o, empty_o)
module sync_fifo
  import if_fetch_q_pkg::*;
#(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic we, re;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o = mem_q[rd_q];
  assign re = pop_i & ~empty_o;
  assign we = push_i & (~full_o | re);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i == RstEnable) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(we);
      rd_q <= rd_q + AW'(re);
      cnt_q <= cnt_q + CW'(we) - CW'(re);
    end
  end
  always_ff @(posedge clk_i)
    if (we & ~clr_i) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/if_fetch_q.sv
// if_fetch_q: fetch stage issuing in-order imem requests from pc_i, squashing on flush_i, queuing inst/pc to decode; IF_FETCH_BYPASS_EN enables zero-latency response bypass
module if_fetch_q
  import if_fetch_q_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int DATA_W = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              id_ready_i
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state_q, state_d;
  logic [CW-1:0] squash_q, squash_d, aq_cnt, if_cnt;
  logic aq_full, aq_empty, if_full, if_empty;
  logic [ADDR_W-1:0] aq_head;
  logic [DATA_W+ADDR_W-1:0] if_head;
  logic [CW:0] used;
  logic space, grant, rv, keep, if_push, if_pop;
  assign used = {1'b0, if_cnt} + {1'b0, aq_cnt};
  assign space = ~aq_full & ~if_full & (used < (CW+1)'(DEPTH));
  assign imem_req_o = pc_valid_i & space & (state_q == S_FETCH) & ~flush_i;
  assign imem_addr_o = pc_i;
  assign grant = imem_req_o & imem_gnt_i;
  assign pc_ready_o = grant;
  // the address queue doubles as the outstanding counter; responses with nothing outstanding are dropped
  assign rv = imem_rvalid_i & ~aq_empty;
  assign keep = rv & (squash_q == '0) & ~flush_i;
  assign if_pop = ~if_empty & id_ready_i;
`ifdef IF_FETCH_BYPASS_EN
  logic byp;
  assign byp = keep & if_empty;
  assign if_push = keep & ~(byp & id_ready_i);
  assign inst_valid_o = ~if_empty | byp;
  assign inst_o = ~if_empty ? if_head[DATA_W+ADDR_W-1:ADDR_W] : byp ? imem_rdata_i : DATA_W'(InstNop);
  assign inst_pc_o = ~if_empty ? if_head[ADDR_W-1:0] : byp ? aq_head : '0;
`else
  assign if_push = keep;
  assign inst_valid_o = ~if_empty;
  assign inst_o = if_empty ? DATA_W'(InstNop) : if_head[DATA_W+ADDR_W-1:ADDR_W];
  assign inst_pc_o = if_empty ? '0 : if_head[ADDR_W-1:0];
`endif
  // every request still in flight at a flush becomes stale, less the one retiring this cycle
  assign squash_d = flush_i ? aq_cnt - CW'(rv) : squash_q - CW'(rv & (squash_q != '0));
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = pc_valid_i ? S_FETCH : S_IDLE;
      S_FETCH: state_d = (flush_i & (squash_d != '0)) ? S_FLUSH : (~pc_valid_i & (aq_cnt == '0)) ? S_IDLE : S_FETCH;
      S_FLUSH: state_d = (squash_d != '0) ? S_FLUSH : pc_valid_i ? S_FETCH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i == RstEnable) begin
      state_q <= S_IDLE;
      squash_q <= '0;
    end else begin
      state_q <= state_d;
      squash_q <= squash_d;
    end
  end
  sync_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_aq (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(1'b0),
    .push_i(grant), .data_i(pc_i), .pop_i(rv), .data_o(aq_head),
    .count_o(aq_cnt), .full_o(aq_full), .empty_o(aq_empty)
  );
  sync_fifo #(.W(DATA_W+ADDR_W), .DEPTH(DEPTH)) u_if (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(flush_i),
    .push_i(if_push), .data_i({imem_rdata_i, aq_head}), .pop_i(if_pop), .data_o(if_head),
    .count_o(if_cnt), .full_o(if_full), .empty_o(if_empty)
  );
endmodule

// File: doc/if_fetch_q.md
Name: if_fetch_q

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the word-addressed PC and its chip-enable, issues in-order requests to instruction memory, and buffers returned instructions with their PC in a small FIFO.
- Presents instructions to the decode stage (if_id) with a valid/ready handshake.
- Supports a pipeline flush that squashes buffered and in-flight fetches.

Parameters:
- ADDR_W, 32, PC / instruction-address width (word address, matches InstAddrBus).
- DATA_W, 32, instruction width.
- DEPTH, 2, instruction FIFO entries; also the maximum number of outstanding requests (power of 2, ≥2).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high (`RstEnable` = 1'b1).
- pc_i  in  ADDR_W  PC to fetch (word address).
- pc_valid_i  in  1  PC valid; driven from the PC register's ce (`ChipEnable`).
- pc_ready_o  out  1  PC consumed this cycle; the PC register advances only when this is 1.
- flush_i  in  1  single-cycle flush pulse (branch/jump redirect).
- imem_req_o  out  1  memory request.
- imem_addr_o  out  ADDR_W  request address.
- imem_gnt_i  in  1  request accepted.
- imem_rvalid_i  in  1  response valid; responses are in order, ≥1 cycle after grant.
- imem_rdata_i  in  DATA_W  response data.
- inst_valid_o  out  1  instruction valid to decode.
- inst_o  out  DATA_W  instruction.
- inst_pc_o  out  ADDR_W  PC of inst_o.
- id_ready_i  in  1  decode accepts the instruction.

Behaviour:
- Reset values:
  - inst_valid_o=0, imem_req_o=0, pc_ready_o=0.
  - inst_o=32'h0000_0013 (NOP), inst_pc_o=0, imem_addr_o=0.
  - FIFO empty, outstanding=0, squash=0, state=S_IDLE.
- Reset is asynchronous and takes effect immediately mid-operation.
- An rvalid arriving when outstanding=0 is ignored.
- Credit: `space = (fifo_count + outstanding) < DEPTH`.
- Request path:
  - `imem_req_o = pc_valid_i & space & (state==S_FETCH) & ~flush_i`.
  - `imem_addr_o = pc_i`.
  - `pc_ready_o = imem_req_o & imem_gnt_i`.
  - On grant, pc_i is pushed into a DEPTH-entry address queue and outstanding increments.
- Response path:
  - On imem_rvalid_i with squash=0: pop the address queue and push {rdata, addr} into the FIFO.
  - With squash>0: pop the address queue, discard the data, and decrement squash.
- Output latency: an instruction is visible on inst_o the cycle after rvalid (without bypass).
- Decode handshake:
  - The FIFO head is driven on inst_o/inst_pc_o; inst_valid_o = FIFO non-empty.
  - The entry pops when inst_valid_o & id_ready_i.
  - Head data is held stable while valid & ~ready.
- Simultaneous push and pop on a full FIFO is legal.
- FIFO pointers wrap modulo DEPTH.
- Flush:
  - The FIFO clears and inst_valid_o=0 the next cycle.
  - squash is set to outstanding, plus 1 for any grant in the same cycle (none possible, since the request is gated by flush_i), minus 1 if rvalid in the same cycle.
  - A response arriving in the flush cycle is discarded.
- States:
  - S_IDLE: pc_valid_i=0 and outstanding=0. Goes to S_FETCH when pc_valid_i=1.
  - S_FETCH: normal operation.
    - flush with squash>0 → S_FLUSH.
    - pc_valid_i=0 and outstanding=0 → S_IDLE.
  - S_FLUSH: no requests are issued. When squash reaches 0, go to S_FETCH (pc_valid_i=1) or S_IDLE.
  - A flush_i pulse while already in S_FLUSH is accepted with no effect beyond the FIFO clear.
- The address queue never overflows, because of the credit rule.

Optional Feature:
- Macro: IF_FETCH_BYPASS_EN.
- With the macro defined:
  - When the FIFO is empty and an un-squashed rvalid arrives, inst_valid_o/inst_o/inst_pc_o are driven combinationally from the response in the same cycle.
  - If id_ready_i=1, the entry is not written to the FIFO.
  - Latency becomes 0 cycles.
- Without the macro: the response is always registered into the FIFO (latency 1 cycle).

Decomposition:
- Shared defines header (alongside `InstAddrBus`/`RstEnable`):
  - the `InstNop` 32'h0000_0013 constant;
  - the state encodings S_IDLE/S_FETCH/S_FLUSH.
- Sub-module: sync_fifo (parameterised width/depth; count, full, empty). Instantiated twice:
  - the address queue (ADDR_W);
  - the instruction FIFO (DATA_W+ADDR_W).

Test Plan:
- Reset then pc_valid_i=1, pc_i=0x0, memory with 1-cycle latency returning 0xAAAA0000+addr, id_ready_i=1 → inst_o sequence 0xAAAA0000, 0xAAAA0001, …, with inst_pc_o matching; inst_valid_o first high 2 cycles after the first grant (1 with bypass).
- id_ready_i=0 for 10 cycles → at most DEPTH=2 grants; inst_o holds the PC-0 instruction steady; pc_ready_o=0 once credit is exhausted.
- Two requests outstanding with 3-cycle latency, flush_i pulsed → squash=2, state S_FLUSH, both responses discarded, inst_valid_o=0; the first post-flush request is issued after the second stale rvalid.
- flush_i in the same cycle as an rvalid with FIFO holding 1 entry → both discarded, FIFO empty the next cycle.
- rst_i asserted asynchronously mid-stream with 1 outstanding → all outputs reset immediately; the late rvalid is ignored; no inst_valid_o.
- pc_valid_i deasserted with 0 outstanding → S_IDLE, imem_req_o=0.
